// File: rtl/vx_tcu_tfr_max_exp_acc_pkg.sv
// Shared helpers for the TCU transform max-exponent accumulator.
package vx_tcu_tfr_max_exp_acc_pkg;

    // Callers extend exponents to 64 bits (sign- or zero-) before comparing.
    function automatic logic tcu_exp_gt(input logic [63:0] a, input logic [63:0] b,
                                        input logic signed_mode);
        return signed_mode ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    function automatic int tcu_maxexp_idxw(input int n, input int beatw);
        return beatw + $clog2(n);
    endfunction

endpackage

// File: rtl/vx_tcu_tfr_max_exp_acc_if.sv
// Beat-in / group-result-out bundle for the max-exponent accumulator.
interface vx_tcu_tfr_max_exp_acc_if
    import vx_tcu_tfr_max_exp_acc_pkg::*;
#(
    parameter int N     = 8,
    parameter int WIDTH = 8,
    parameter int BEATW = 4
) ();
    localparam int IW = tcu_maxexp_idxw(N, BEATW);

    logic                 valid_in;
    logic                 ready_in;
    logic [N*WIDTH-1:0]   exponents;
    logic [N-1:0]         lane_mask;
    logic                 last_in;
    logic                 valid_out;
    logic                 ready_out;
    logic [WIDTH-1:0]     max_exp;
    logic [IW-1:0]        max_idx;
    logic                 none_valid;
    logic [BEATW-1:0]     beat_cnt;
    logic                 overflow;

    modport master (
        output valid_in, exponents, lane_mask, last_in, ready_out,
        input  ready_in, valid_out, max_exp, max_idx, none_valid, beat_cnt, overflow
    );

    modport slave (
        input  valid_in, exponents, lane_mask, last_in, ready_out,
        output ready_in, valid_out, max_exp, max_idx, none_valid, beat_cnt, overflow
    );
endinterface

// File: rtl/vx_tcu_tfr_max_exp_acc_lane_argmax.sv
// Combinational masked arg-max over N lanes; ties go to the lowest lane.
module vx_tcu_tfr_max_exp_acc_lane_argmax
    import vx_tcu_tfr_max_exp_acc_pkg::*;
#(
    parameter int N      = 8,
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic [N*WIDTH-1:0]     exps,
    input  logic [N-1:0]           mask,
    output logic [WIDTH-1:0]       max_exp,
    output logic [$clog2(N)-1:0]   max_lane,
    output logic                   any_lane
);
    localparam int IDXW = $clog2(N);

    function automatic logic [63:0] ext(input logic [WIDTH-1:0] x);
        return (SIGNED != 0) ? 64'($signed(x)) : 64'(x);
    endfunction

    logic [N-1:0] win;

    // Lane i wins if it strictly beats every unmasked lower lane and is not
    // beaten by any unmasked higher lane, which makes win one-hot.
    for (genvar i = 0; i < N; i++) begin : g_row
        logic [N-1:0] beats;
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j < i) begin : g_lo
                assign beats[j] = ~mask[j] | tcu_exp_gt(ext(exps[i*WIDTH +: WIDTH]),
                                                        ext(exps[j*WIDTH +: WIDTH]), SIGNED != 0);
            end else if (j > i) begin : g_hi
                assign beats[j] = ~mask[j] | ~tcu_exp_gt(ext(exps[j*WIDTH +: WIDTH]),
                                                         ext(exps[i*WIDTH +: WIDTH]), SIGNED != 0);
            end else begin : g_self
                assign beats[j] = 1'b1;
            end
        end
        assign win[i] = mask[i] & (&beats);
    end

    always_comb begin
        max_exp  = '0;
        max_lane = '0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) begin
                max_exp  = max_exp | exps[i*WIDTH +: WIDTH];
                max_lane = max_lane | IDXW'(i);
            end
        end
    end

    assign any_lane = |mask;
endmodule

// File: rtl/vx_tcu_tfr_max_exp_acc.sv
// Two-stage masked arg-max exponent accumulator over multi-beat groups.
module vx_tcu_tfr_max_exp_acc
    import vx_tcu_tfr_max_exp_acc_pkg::*;
#(
    parameter int N      = 8,
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0,
    parameter int BEATW  = 4
) (
    input  logic clk,
    input  logic reset,
    vx_tcu_tfr_max_exp_acc_if.slave io
);
    localparam int IDXW = $clog2(N);
    localparam int IW   = tcu_maxexp_idxw(N, BEATW);
    localparam logic [BEATW-1:0] CNT_MAX = '1;

    function automatic logic [63:0] ext(input logic [WIDTH-1:0] x);
        return (SIGNED != 0) ? 64'($signed(x)) : 64'(x);
    endfunction

    logic              en;
    logic [WIDTH-1:0]  lane_exp;
    logic [IDXW-1:0]   lane_sel;
    logic              lane_any;

    logic              s1_valid, s1_any, s1_last;
    logic [WIDTH-1:0]  s1_exp;
    logic [IDXW-1:0]   s1_lane;

    logic              acc_active, acc_any, acc_ovf;
    logic [WIDTH-1:0]  acc_exp;
    logic [IW-1:0]     acc_idx;
    logic [BEATW-1:0]  acc_cnt;

    logic              any_nxt, ovf_nxt;
    logic [WIDTH-1:0]  exp_nxt;
    logic [IW-1:0]     idx_nxt;
    logic [BEATW-1:0]  cnt_nxt;

    // A pending, unaccepted result freezes the whole pipe.
    assign en          = ~io.valid_out | io.ready_out;
    assign io.ready_in = en;

    vx_tcu_tfr_max_exp_acc_lane_argmax #(
        .N(N), .WIDTH(WIDTH), .SIGNED(SIGNED)
    ) u_argmax (
        .exps(io.exponents), .mask(io.lane_mask),
        .max_exp(lane_exp), .max_lane(lane_sel), .any_lane(lane_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_exp   <= '0;
            s1_lane  <= '0;
            s1_any   <= 1'b0;
            s1_last  <= 1'b0;
        end else if (en) begin
            s1_valid <= io.valid_in;
            s1_exp   <= lane_exp;
            s1_lane  <= lane_sel;
            s1_any   <= lane_any;
            s1_last  <= io.last_in;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        ovf_nxt = 1'b0;
        exp_nxt = s1_exp;
        idx_nxt = {{BEATW{1'b0}}, s1_lane};
        any_nxt = s1_any;
        if (acc_active) begin
            cnt_nxt = (acc_cnt == CNT_MAX) ? acc_cnt : acc_cnt + BEATW'(1);
            ovf_nxt = acc_ovf | (acc_cnt == CNT_MAX);
            exp_nxt = acc_exp;
            idx_nxt = acc_idx;
            any_nxt = acc_any;
            // Strict compare: a tie keeps the earlier beat.
            if (s1_any && (!acc_any || tcu_exp_gt(ext(s1_exp), ext(acc_exp), SIGNED != 0))) begin
                exp_nxt = s1_exp;
                idx_nxt = {cnt_nxt, s1_lane};
                any_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_active    <= 1'b0;
            acc_any       <= 1'b0;
            acc_ovf       <= 1'b0;
            acc_exp       <= '0;
            acc_idx       <= '0;
            acc_cnt       <= '0;
            io.valid_out  <= 1'b0;
            io.max_exp    <= '0;
            io.max_idx    <= '0;
            io.none_valid <= 1'b0;
            io.beat_cnt   <= '0;
            io.overflow   <= 1'b0;
        end else if (en) begin
            io.valid_out <= s1_valid & s1_last;
            if (s1_valid) begin
                acc_active <= ~s1_last;
                acc_any    <= any_nxt;
                acc_ovf    <= ovf_nxt;
                acc_exp    <= exp_nxt;
                acc_idx    <= idx_nxt;
                acc_cnt    <= cnt_nxt;
                if (s1_last) begin
                    io.max_exp    <= exp_nxt;
                    io.max_idx    <= idx_nxt;
                    io.none_valid <= ~any_nxt;
                    io.beat_cnt   <= cnt_nxt;
                    io.overflow   <= ovf_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_vx_tcu_tfr_max_exp_acc.sv
// Drives three configurations (unsigned, signed, BEATW=2) with one shared beat
// stream and compares each against a per-group arg-max reference model.
module tb_vx_tcu_tfr_max_exp_acc;
    localparam int N = 8;
    localparam int W = 8;

    typedef struct packed {
        logic [7:0] e;
        logic [6:0] idx;
        logic       none;
        logic [3:0] cnt;
        logic       ovf;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             valid_in = 1'b0;
    logic             last_in = 1'b0;
    logic             ready_out = 1'b1;
    logic [N*W-1:0]   exponents = '0;
    logic [N-1:0]     lane_mask = '0;
    bit               rand_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    res_t obs_q[3][$];
    res_t exp_q[3][$];
    logic [N*W-1:0] grp_e[$];
    logic [N-1:0]   grp_m[$];

    vx_tcu_tfr_max_exp_acc_if #(.N(N), .WIDTH(W), .BEATW(4)) if0 ();
    vx_tcu_tfr_max_exp_acc_if #(.N(N), .WIDTH(W), .BEATW(4)) if1 ();
    vx_tcu_tfr_max_exp_acc_if #(.N(N), .WIDTH(W), .BEATW(2)) if2 ();

    assign if0.valid_in = valid_in;   assign if1.valid_in = valid_in;   assign if2.valid_in = valid_in;
    assign if0.exponents = exponents; assign if1.exponents = exponents; assign if2.exponents = exponents;
    assign if0.lane_mask = lane_mask; assign if1.lane_mask = lane_mask; assign if2.lane_mask = lane_mask;
    assign if0.last_in = last_in;     assign if1.last_in = last_in;     assign if2.last_in = last_in;
    assign if0.ready_out = ready_out; assign if1.ready_out = ready_out; assign if2.ready_out = ready_out;

    vx_tcu_tfr_max_exp_acc #(.N(N), .WIDTH(W), .SIGNED(0), .BEATW(4)) u_dut (.clk(clk), .reset(reset), .io(if0));
    vx_tcu_tfr_max_exp_acc #(.N(N), .WIDTH(W), .SIGNED(1), .BEATW(4)) u_sgn (.clk(clk), .reset(reset), .io(if1));
    vx_tcu_tfr_max_exp_acc #(.N(N), .WIDTH(W), .SIGNED(0), .BEATW(2)) u_bw2 (.clk(clk), .reset(reset), .io(if2));

    // Reference: scan the whole group beat-major, lane-minor, keep the first strict maximum.
    function automatic res_t model(input int c);
        res_t r;
        int sat, nb, best, key, bb, bl;
        logic found;
        logic [N*W-1:0] e;
        logic [N-1:0] m;
        logic [7:0] v, bv;
        sat = (c == 2) ? 3 : 15;
        nb = grp_e.size();
        found = 1'b0; best = 0; bb = 0; bl = 0; bv = '0;
        for (int b = 0; b < nb; b++) begin
            e = grp_e[b];
            m = grp_m[b];
            for (int l = 0; l < N; l++) begin
                if (m[l]) begin
                    v = e[l*W +: W];
                    key = (c == 1) ? int'($signed(v)) : int'(v);
                    if (!found || key > best) begin
                        found = 1'b1; best = key; bb = b; bl = l; bv = v;
                    end
                end
            end
        end
        r.e    = bv;
        r.idx  = found ? 7'((((bb > sat) ? sat : bb) << 3) | bl) : 7'd0;
        r.none = !found;
        r.cnt  = 4'(((nb - 1) > sat) ? sat : (nb - 1));
        r.ovf  = (nb - 1) > sat;
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            grp_e.delete(); grp_m.delete();
            for (int c = 0; c < 3; c++) exp_q[c].delete();
        end else if (valid_in && if0.ready_in) begin
            grp_e.push_back(exponents);
            grp_m.push_back(lane_mask);
            if (last_in) begin
                for (int c = 0; c < 3; c++) exp_q[c].push_back(model(c));
                grp_e.delete(); grp_m.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (if0.valid_out && if0.ready_out)
            obs_q[0].push_back(res_t'{e: if0.max_exp, idx: 7'(if0.max_idx), none: if0.none_valid,
                                      cnt: 4'(if0.beat_cnt), ovf: if0.overflow});
        if (if1.valid_out && if1.ready_out)
            obs_q[1].push_back(res_t'{e: if1.max_exp, idx: 7'(if1.max_idx), none: if1.none_valid,
                                      cnt: 4'(if1.beat_cnt), ovf: if1.overflow});
        if (if2.valid_out && if2.ready_out)
            obs_q[2].push_back(res_t'{e: if2.max_exp, idx: 7'(if2.max_idx), none: if2.none_valid,
                                      cnt: 4'(if2.beat_cnt), ovf: if2.overflow});
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 ready_out = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Presents one beat and holds it until the block accepts it.
    task automatic send(input logic [N*W-1:0] e, input logic [N-1:0] m, input logic l);
        int guard;
        valid_in = 1'b1; exponents = e; lane_mask = m; last_in = l;
        guard = 0;
        @(negedge clk);
        while (!if0.ready_in && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 50) begin
            n_fail++;
            $display("FAIL send_timeout: ready_in stayed 0 for %0d cycles, required 1", guard);
        end
        @(posedge clk); #1;
        valid_in = 1'b0; last_in = 1'b0;
    endtask

    function automatic logic [N*W-1:0] rand_exps(input int lo, input int hi);
        logic [N*W-1:0] e;
        for (int l = 0; l < N; l++) e[l*W +: W] = 8'($urandom_range(lo, hi));
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 8;
        if (if0.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b expected 0", if0.valid_out); end
        if (if0.ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready_in: got %b expected 1", if0.ready_in); end
        if (if0.max_exp !== 8'd0) begin n_fail++; $display("FAIL reset_max_exp: got %h expected 00", if0.max_exp); end
        if (if0.max_idx !== 7'd0) begin n_fail++; $display("FAIL reset_max_idx: got %h expected 00", if0.max_idx); end
        if (if0.none_valid !== 1'b0) begin n_fail++; $display("FAIL reset_none_valid: got %b expected 0", if0.none_valid); end
        if (if0.beat_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d expected 0", if0.beat_cnt); end
        if (if0.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", if0.overflow); end
        if (if2.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out_bw2: got %b expected 0", if2.valid_out); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        res_t got, want;
        valid_in = 1'b1; last_in = 1'b1; lane_mask = 8'hFF;
        exponents = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd9, 8'd9, 8'd3};
        @(posedge clk); #1;
        valid_in = 1'b0; last_in = 1'b0;
        n_checks++;
        if (if0.valid_out !== 1'b0) begin n_fail++; $display("FAIL single_early: valid_out got %b expected 0", if0.valid_out); end
        @(posedge clk); #1;
        n_checks += 5;
        if (if0.valid_out !== 1'b1) begin n_fail++; $display("FAIL single_latency: valid_out got %b expected 1", if0.valid_out); end
        if (if0.max_exp !== 8'd9) begin n_fail++; $display("FAIL single_exp: got %0d expected 9", if0.max_exp); end
        if (if0.max_idx !== 7'd1) begin n_fail++; $display("FAIL single_idx: got %0d expected 1", if0.max_idx); end
        if (if0.none_valid !== 1'b0) begin n_fail++; $display("FAIL single_none: got %b expected 0", if0.none_valid); end
        if (if0.beat_cnt !== 4'd0) begin n_fail++; $display("FAIL single_cnt: got %0d expected 0", if0.beat_cnt); end
        repeat (6) @(posedge clk); #2;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (obs_q[c].size() != exp_q[c].size()) begin
                n_fail++; $display("FAIL single_count dut%0d: got %0d results expected %0d", c, obs_q[c].size(), exp_q[c].size());
            end
            while (obs_q[c].size() > 0 && exp_q[c].size() > 0) begin
                got = obs_q[c].pop_front(); want = exp_q[c].pop_front(); n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL single_sb dut%0d: got %h expected %h", c, got, want); end
            end
            obs_q[c].delete(); exp_q[c].delete();
        end
    endtask

    task automatic test_multi_beat();
        res_t got, want;
        logic [N*W-1:0] e;
        e = rand_exps(0, 4);   e[2*W +: W] = 8'd5;  send(e, 8'hFF, 1'b0);
        e = rand_exps(0, 11);  e[2*W +: W] = 8'd12; send(e, 8'hFF, 1'b0);
        e = rand_exps(0, 11);  e[2*W +: W] = 8'd12; send(e, 8'hFF, 1'b1);
        @(posedge clk); #1;
        n_checks += 4;
        if (if0.valid_out !== 1'b1) begin n_fail++; $display("FAIL multi_valid: got %b expected 1", if0.valid_out); end
        if (if0.max_exp !== 8'd12) begin n_fail++; $display("FAIL multi_exp: got %0d expected 12", if0.max_exp); end
        if (if0.max_idx !== 7'd10) begin n_fail++; $display("FAIL multi_idx: got %0d expected 10", if0.max_idx); end
        if (if0.beat_cnt !== 4'd2) begin n_fail++; $display("FAIL multi_cnt: got %0d expected 2", if0.beat_cnt); end
        repeat (6) @(posedge clk); #2;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (obs_q[c].size() != exp_q[c].size()) begin
                n_fail++; $display("FAIL multi_count dut%0d: got %0d results expected %0d", c, obs_q[c].size(), exp_q[c].size());
            end
            while (obs_q[c].size() > 0 && exp_q[c].size() > 0) begin
                got = obs_q[c].pop_front(); want = exp_q[c].pop_front(); n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL multi_sb dut%0d: got %h expected %h", c, got, want); end
            end
            obs_q[c].delete(); exp_q[c].delete();
        end
    endtask

    task automatic test_signed_and_masked();
        res_t got, want;
        send({8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hF8, 8'hFF, 8'hFD}, 8'hFD, 1'b1);
        @(posedge clk); #1;
        n_checks += 3;
        if (if1.valid_out !== 1'b1) begin n_fail++; $display("FAIL signed_valid: got %b expected 1", if1.valid_out); end
        if (if1.max_exp !== 8'hFE) begin n_fail++; $display("FAIL signed_exp: got %h expected fe", if1.max_exp); end
        if (if1.max_idx !== 7'd3) begin n_fail++; $display("FAIL signed_idx: got %0d expected 3", if1.max_idx); end
        send(rand_exps(0, 255), 8'h00, 1'b0);
        send(rand_exps(0, 255), 8'h00, 1'b1);
        @(posedge clk); #1;
        n_checks += 4;
        if (if0.none_valid !== 1'b1) begin n_fail++; $display("FAIL masked_none: got %b expected 1", if0.none_valid); end
        if (if0.max_exp !== 8'd0) begin n_fail++; $display("FAIL masked_exp: got %h expected 00", if0.max_exp); end
        if (if0.max_idx !== 7'd0) begin n_fail++; $display("FAIL masked_idx: got %h expected 00", if0.max_idx); end
        if (if0.beat_cnt !== 4'd1) begin n_fail++; $display("FAIL masked_cnt: got %0d expected 1", if0.beat_cnt); end
        repeat (6) @(posedge clk); #2;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (obs_q[c].size() != exp_q[c].size()) begin
                n_fail++; $display("FAIL sgnmask_count dut%0d: got %0d results expected %0d", c, obs_q[c].size(), exp_q[c].size());
            end
            while (obs_q[c].size() > 0 && exp_q[c].size() > 0) begin
                got = obs_q[c].pop_front(); want = exp_q[c].pop_front(); n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL sgnmask_sb dut%0d: got %h expected %h", c, got, want); end
            end
            obs_q[c].delete(); exp_q[c].delete();
        end
    endtask

    task automatic test_overflow();
        res_t got, want;
        logic [N*W-1:0] e;
        for (int b = 0; b < 6; b++) begin
            e = rand_exps(0, 199);
            if (b == 5) e[4*W +: W] = 8'd200;
            send(e, 8'hFF, b == 5);
        end
        @(posedge clk); #1;
        n_checks += 6;
        if (if2.beat_cnt !== 2'd3) begin n_fail++; $display("FAIL ovf_cnt_bw2: got %0d expected 3", if2.beat_cnt); end
        if (if2.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag_bw2: got %b expected 1", if2.overflow); end
        if (if2.max_idx !== 5'd28) begin n_fail++; $display("FAIL ovf_idx_bw2: got %0d expected 28", if2.max_idx); end
        if (if2.max_exp !== 8'd200) begin n_fail++; $display("FAIL ovf_exp_bw2: got %0d expected 200", if2.max_exp); end
        if (if0.beat_cnt !== 4'd5) begin n_fail++; $display("FAIL ovf_cnt_bw4: got %0d expected 5", if0.beat_cnt); end
        if (if0.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_flag_bw4: got %b expected 0", if0.overflow); end
        repeat (6) @(posedge clk); #2;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (obs_q[c].size() != exp_q[c].size()) begin
                n_fail++; $display("FAIL ovf_count dut%0d: got %0d results expected %0d", c, obs_q[c].size(), exp_q[c].size());
            end
            while (obs_q[c].size() > 0 && exp_q[c].size() > 0) begin
                got = obs_q[c].pop_front(); want = exp_q[c].pop_front(); n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL ovf_sb dut%0d: got %h expected %h", c, got, want); end
            end
            obs_q[c].delete(); exp_q[c].delete();
        end
    endtask

    task automatic test_backpressure();
        res_t got, want, snap;
        ready_out = 1'b0;
        send(rand_exps(0, 255), 8'($urandom_range(1, 255)), 1'b1);
        @(posedge clk); #1;
        // Offer a beat while stalled; it must never be taken.
        valid_in = 1'b1; last_in = 1'b1; exponents = rand_exps(0, 255); lane_mask = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            snap = '{e: if0.max_exp, idx: if0.max_idx, none: if0.none_valid, cnt: if0.beat_cnt, ovf: if0.overflow};
            n_checks += 3;
            if (if0.valid_out !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc%0d: got %b expected 1", k, if0.valid_out); end
            if (if0.ready_in !== 1'b0) begin n_fail++; $display("FAIL stall_ready_in cyc%0d: got %b expected 0", k, if0.ready_in); end
            if (exp_q[0].size() != 1 || snap !== exp_q[0][0]) begin
                n_fail++; $display("FAIL stall_hold cyc%0d: got %h expected model result", k, snap);
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0; last_in = 1'b0; ready_out = 1'b1;
        repeat (6) @(posedge clk); #2;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (obs_q[c].size() != 1 || exp_q[c].size() != 1) begin
                n_fail++; $display("FAIL stall_count dut%0d: got %0d results expected 1", c, obs_q[c].size());
            end
            while (obs_q[c].size() > 0 && exp_q[c].size() > 0) begin
                got = obs_q[c].pop_front(); want = exp_q[c].pop_front(); n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL stall_sb dut%0d: got %h expected %h", c, got, want); end
            end
            obs_q[c].delete(); exp_q[c].delete();
        end
    endtask

    task automatic test_reset_mid_group();
        res_t got, want;
        ready_out = 1'b0;
        send(rand_exps(0, 255), 8'hFF, 1'b1);
        send(rand_exps(0, 255), 8'hFF, 1'b0);
        reset = 1'b1;
        #1;
        n_checks += 2;
        if (if0.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", if0.valid_out); end
        if (if0.ready_in !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready_in: got %b expected 1", if0.ready_in); end
        @(posedge clk); #1;
        reset = 1'b0; ready_out = 1'b1;
        @(posedge clk); #1;
        send(rand_exps(0, 255), 8'($urandom), 1'b0);
        send(rand_exps(0, 255), 8'($urandom), 1'b1);
        repeat (6) @(posedge clk); #2;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (obs_q[c].size() != 1 || exp_q[c].size() != 1) begin
                n_fail++; $display("FAIL rst_mid_count dut%0d: got %0d results expected 1", c, obs_q[c].size());
            end
            while (obs_q[c].size() > 0 && exp_q[c].size() > 0) begin
                got = obs_q[c].pop_front(); want = exp_q[c].pop_front(); n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL rst_mid_sb dut%0d: got %h expected %h", c, got, want); end
            end
            obs_q[c].delete(); exp_q[c].delete();
        end
    endtask

    task automatic test_back_to_back();
        res_t got, want;
        for (int g = 0; g < 6; g++) begin
            if (g % 2 == 1) send(rand_exps(0, 255), 8'($urandom), 1'b0);
            send(rand_exps(0, 255), 8'($urandom), 1'b1);
        end
        repeat (6) @(posedge clk); #2;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (obs_q[c].size() != 6 || exp_q[c].size() != 6) begin
                n_fail++; $display("FAIL b2b_count dut%0d: got %0d results expected 6", c, obs_q[c].size());
            end
            while (obs_q[c].size() > 0 && exp_q[c].size() > 0) begin
                got = obs_q[c].pop_front(); want = exp_q[c].pop_front(); n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL b2b_sb dut%0d: got %h expected %h", c, got, want); end
            end
            obs_q[c].delete(); exp_q[c].delete();
        end
    endtask

    task automatic test_random();
        res_t got, want;
        int nb;
        logic [N-1:0] m;
        rand_ready = 1'b1;
        for (int g = 0; g < 25; g++) begin
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                m = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
                send(rand_exps(0, ($urandom_range(0, 1) != 0) ? 255 : 7), m, b == nb - 1);
            end
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        ready_out = 1'b1;
        repeat (8) @(posedge clk); #2;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (obs_q[c].size() != 25 || exp_q[c].size() != 25) begin
                n_fail++; $display("FAIL rand_count dut%0d: got %0d results expected 25", c, obs_q[c].size());
            end
            while (obs_q[c].size() > 0 && exp_q[c].size() > 0) begin
                got = obs_q[c].pop_front(); want = exp_q[c].pop_front(); n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL rand_sb dut%0d: got %h expected %h", c, got, want); end
            end
            obs_q[c].delete(); exp_q[c].delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_signed_and_masked();
        test_overflow();
        test_backpressure();
        test_reset_mid_group();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
